stmt_trace_buffer: RTL and testbench

- Hardware successor to per-statement DPI breakpoint tracing.
- Captures statement-hit events from NUM_CH instrumented channels and round-robin arbitrates them into a circular trace FIFO.
- Matches events against NUM_BP programmable breakpoints and raises a halt/resume handshake.
- Sits beside each instrumented instance; the debug host drains the FIFO over valid/ready.

---
 rtl/stmt_trace_buffer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_stmt_trace_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stmt_trace_buffer.sv
// Statement-hit trace buffer: per-channel pending capture, round-robin arbitration into a circular
// trace FIFO, breakpoint match with halt/resume. Optional macro STMT_TRACE_WRAP_EN: overwrite oldest on full.
module stmt_trace_buffer #(
    parameter int NUM_CH = 4,
    parameter int STMT_W = 16,
    parameter int INST_W = 16,
    parameter logic [INST_W-1:0] INSTANCE_ID = '0,
    parameter int DEPTH = 16,
    parameter int NUM_BP = 2,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BP_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1,
    localparam int ENT_W = INST_W + CH_W + STMT_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trace_en,
    input  logic [NUM_CH-1:0]        hit_valid,
    input  logic [NUM_CH*STMT_W-1:0] hit_stmt,
    input  logic                     bp_wr,
    input  logic [BP_W-1:0]          bp_idx,
    input  logic                     bp_en,
    input  logic [CH_W-1:0]          bp_ch,
    input  logic [STMT_W-1:0]        bp_stmt,
    input  logic                     resume,
    output logic                     halt,
    output logic [BP_W-1:0]          halt_bp,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [ENT_W-1:0]         rd_data,
    output logic [CNT_W-1:0]         count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} halt_state_e;

    logic [NUM_CH-1:0] pend_valid_q, pend_valid_d;
    logic [STMT_W-1:0] pend_stmt_q [NUM_CH];
    logic [NUM_CH-1:0] pend_load_s, pend_drop_s;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              gnt_valid_s;
    logic [CH_W-1:0]   gnt_ch_s;
    logic [NUM_CH-1:0] gnt_oh_s;
    logic [STMT_W-1:0] gnt_stmt_s;
    logic [ENT_W-1:0]  gnt_entry_s;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              pop_s, fifo_full_s, mem_we_s, fifo_drop_s, grow_s, shrink_s;
    logic              ovf_q, ovf_d;

    logic              bp_en_q   [NUM_BP];
    logic [CH_W-1:0]   bp_ch_q   [NUM_BP];
    logic [STMT_W-1:0] bp_stmt_q [NUM_BP];
    logic              bp_match_s;
    logic [BP_W-1:0]   bp_match_idx_s;

    halt_state_e       state_q;
    logic [BP_W-1:0]   halt_bp_q;

    // Round-robin grant: first full pending register at or after the pointer.
    always_comb begin
        int unsigned idx_v;
        gnt_valid_s = 1'b0;
        gnt_ch_s    = '0;
        idx_v       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_v = (int'(rr_ptr_q) + i) % NUM_CH;
            if (!gnt_valid_s && pend_valid_q[CH_W'(idx_v)]) begin
                gnt_valid_s = 1'b1;
                gnt_ch_s    = CH_W'(idx_v);
            end else begin
                gnt_valid_s = gnt_valid_s;
            end
        end
    end

    // Granted channel decode, entry formation and pointer advance.
    always_comb begin
        gnt_oh_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gnt_oh_s[c] = gnt_valid_s && (gnt_ch_s == CH_W'(c));
        end
        gnt_stmt_s  = pend_stmt_q[gnt_ch_s];
        gnt_entry_s = {INSTANCE_ID, gnt_ch_s, gnt_stmt_s};
        if (!gnt_valid_s) begin
            rr_ptr_d = rr_ptr_q;
        end else if (gnt_ch_s == CH_W'(NUM_CH - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = gnt_ch_s + CH_W'(1);
        end
    end

    // Pending capture: a slot being granted this cycle may accept a new hit.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_load_s  = '0;
        pend_drop_s  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (trace_en && hit_valid[c]) begin
                if (pend_valid_q[c] && !gnt_oh_s[c]) begin
                    pend_drop_s[c] = 1'b1;
                end else begin
                    pend_load_s[c]  = 1'b1;
                    pend_valid_d[c] = 1'b1;
                end
            end else if (gnt_oh_s[c]) begin
                pend_valid_d[c] = 1'b0;
            end else begin
                pend_valid_d[c] = pend_valid_q[c];
            end
        end
    end

    assign pop_s       = rd_valid_q && rd_ready;
    assign fifo_full_s = (count_q == CNT_W'(DEPTH));

    // FIFO pointer and occupancy update, including the full-without-pop policy.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_we_s    = 1'b0;
        fifo_drop_s = 1'b0;
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (gnt_valid_s) begin
            if (!fifo_full_s || pop_s) begin
                mem_we_s = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
`ifdef STMT_TRACE_WRAP_EN
                mem_we_s    = 1'b1;
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                fifo_drop_s = 1'b1;
`else
                fifo_drop_s = 1'b1;
`endif
            end
        end else begin
            mem_we_s = 1'b0;
        end
        grow_s   = mem_we_s && !pop_s && !fifo_full_s;
        shrink_s = pop_s && !mem_we_s;
        if (grow_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (shrink_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        rd_valid_d = (count_d != CNT_W'(0));
    end

    // Sticky overflow: a drop in the same cycle beats a clear.
    always_comb begin
        if ((|pend_drop_s) || fifo_drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Breakpoint comparators; descending scan leaves the lowest matching index.
    always_comb begin
        bp_match_s     = 1'b0;
        bp_match_idx_s = '0;
        for (int b = NUM_BP - 1; b >= 0; b--) begin
            if (bp_en_q[b] && (bp_ch_q[b] == gnt_ch_s) && (bp_stmt_q[b] == gnt_stmt_s)) begin
                bp_match_s     = 1'b1;
                bp_match_idx_s = BP_W'(b);
            end else begin
                bp_match_s = bp_match_s;
            end
        end
    end

    // Capture, arbitration and FIFO state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_valid_q   <= 1'b0;
            ovf_q        <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend_stmt_q[c] <= '0;
            end
            for (int d = 0; d < DEPTH; d++) begin
                mem_q[d] <= '0;
            end
        end else begin
            pend_valid_q <= pend_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_valid_q   <= rd_valid_d;
            ovf_q        <= ovf_d;
            for (int c = 0; c < NUM_CH; c++) begin
                if (pend_load_s[c]) begin
                    pend_stmt_q[c] <= hit_stmt[c*STMT_W +: STMT_W];
                end
            end
            if (mem_we_s) begin
                mem_q[wr_ptr_q] <= gnt_entry_s;
            end
        end
    end

    // Breakpoint slot registers; indices beyond NUM_BP match no slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BP; b++) begin
                bp_en_q[b]   <= 1'b0;
                bp_ch_q[b]   <= '0;
                bp_stmt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BP; b++) begin
                if (bp_wr && (bp_idx == BP_W'(b))) begin
                    bp_en_q[b]   <= bp_en;
                    bp_ch_q[b]   <= bp_ch;
                    bp_stmt_q[b] <= bp_stmt;
                end
            end
        end
    end

    // Halt handshake FSM; compares only run while not halted and not resuming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            halt_bp_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (gnt_valid_s && bp_match_s) begin
                        state_q   <= ST_HALT;
                        halt_bp_q <= bp_match_idx_s;
                    end else begin
                        state_q   <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_HALT;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign halt     = (state_q == ST_HALT);
    assign halt_bp  = halt_bp_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_stmt_trace_buffer.sv
// Directed bench for stmt_trace_buffer: vector table for capture/FIFO flows plus
// hand-written sequences for breakpoints, full FIFO and asynchronous reset.
module tb_stmt_trace_buffer;

    logic        clk, rst_n, trace_en, bp_wr, bp_en, resume, rd_ready, clr_ovf;
    logic [3:0]  hit_valid;
    logic [63:0] hit_stmt;
    logic [0:0]  bp_idx;
    logic [1:0]  bp_ch;
    logic [15:0] bp_stmt;
    logic        halt, rd_valid, overflow;
    logic [0:0]  halt_bp;
    logic [33:0] rd_data;
    logic [4:0]  count;

    int checks = 0;
    int failures = 0;

    stmt_trace_buffer #(.INSTANCE_ID(16'h00A1)) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .hit_valid(hit_valid), .hit_stmt(hit_stmt),
        .bp_wr(bp_wr), .bp_idx(bp_idx), .bp_en(bp_en), .bp_ch(bp_ch), .bp_stmt(bp_stmt),
        .resume(resume), .halt(halt), .halt_bp(halt_bp), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000ns");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          rst;
        logic        en;
        logic [3:0]  hv;
        logic [63:0] st;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [4:0]  ec;
        logic        eo;
        logic        cd;
        logic [33:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rst, input logic en, input logic [3:0] hv, input logic [63:0] st,
                                input logic rdy, input logic clr, input logic ev, input logic [4:0] ec,
                                input logic eo, input logic cd, input logic [33:0] ed);
        vec_t v;
        v.rst = rst; v.en = en; v.hv = hv; v.st = st; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ec = ec; v.eo = eo; v.cd = cd; v.ed = ed;
        return v;
    endfunction

    function automatic logic [33:0] ent(input logic [1:0] ch, input logic [15:0] s);
        return {16'h00A1, ch, s};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        trace_en = 1'b1; hit_valid = 4'b0; hit_stmt = 64'h0;
        bp_wr = 1'b0; bp_idx = 1'b0; bp_en = 1'b0; bp_ch = 2'd0; bp_stmt = 16'h0;
        resume = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_halt_bp", 64'(halt_bp), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic hit1(input int ch, input logic [15:0] s);
        hit_valid = 4'b0001 << ch;
        hit_stmt  = {4{s}};
        step();
        hit_valid = 4'b0;
    endtask

    task automatic bp_write(input logic [0:0] idx, input logic en, input logic [1:0] ch, input logic [15:0] s);
        bp_wr = 1'b1; bp_idx = idx; bp_en = en; bp_ch = ch; bp_stmt = s;
        step();
        bp_wr = 1'b0;
    endtask

    logic [15:0] exp_s [16];

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Single hit on ch2
        vecs.push_back(mk(1'b1, 1'b1, 4'b0100, 64'h0000_0005_0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 34'h0));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, ent(2'd2, 16'h0005)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 34'h0));
        // Simultaneous hits drained in channel order
        vecs.push_back(mk(1'b1, 1'b1, 4'b1111, 64'h0013_0012_0011_0010, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 34'h0));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, ent(2'd0, 16'h0010)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, ent(2'd1, 16'h0011)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, ent(2'd2, 16'h0012)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, ent(2'd3, 16'h0013)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 34'h0));
        // trace_en=0 blocks capture
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 64'h0013_0012_0011_0010, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 34'h0));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 34'h0));
        // Pending collision: ch1..3 second hits lost, ch0 reloads as it is granted
        vecs.push_back(mk(1'b1, 1'b1, 4'b1111, 64'h0023_0022_0021_0020, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 34'h0));
        vecs.push_back(mk(1'b0, 1'b1, 4'b1111, 64'h0033_0032_0031_0030, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, ent(2'd0, 16'h0020)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, ent(2'd0, 16'h0020)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 34'h0));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 34'h0));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, ent(2'd0, 16'h0020)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, ent(2'd0, 16'h0020)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, ent(2'd1, 16'h0021)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, ent(2'd2, 16'h0022)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, ent(2'd3, 16'h0023)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, ent(2'd0, 16'h0030)));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 34'h0));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 34'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            trace_en = vecs[i].en; hit_valid = vecs[i].hv; hit_stmt = vecs[i].st;
            rd_ready = vecs[i].rdy; clr_ovf = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ec));
            chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].eo));
            if (vecs[i].cd) chk($sformatf("vec%0d_rd_data", i), 64'(rd_data), 64'(vecs[i].ed));
        end
        idle_inputs();

        // Breakpoint halt, hold while halted, resume, resume racing a grant, lowest index wins
        do_reset();
        bp_write(1'b1, 1'b1, 2'd1, 16'h0003);
        bp_write(1'b0, 1'b1, 2'd0, 16'h0007);
        hit1(1, 16'h0003);
        chk("bp_pre_halt", 64'(halt), 64'd0);
        step();
        chk("bp_halt", 64'(halt), 64'd1);
        chk("bp_halt_bp", 64'(halt_bp), 64'd1);
        chk("bp_count", 64'(count), 64'd1);
        hit1(0, 16'h0007);
        step();
        chk("bp_hold_halt", 64'(halt), 64'd1);
        chk("bp_hold_idx", 64'(halt_bp), 64'd1);
        chk("bp_hold_count", 64'(count), 64'd2);
        resume = 1'b1; step(); resume = 1'b0;
        chk("bp_resume", 64'(halt), 64'd0);
        hit1(1, 16'h0003);
        step();
        chk("bp_rehalt", 64'(halt), 64'd1);
        hit1(1, 16'h0003);
        resume = 1'b1; step(); resume = 1'b0;
        chk("bp_resume_grant", 64'(halt), 64'd0);
        chk("bp_resume_grant_cnt", 64'(count), 64'd4);
        step();
        chk("bp_resume_stay", 64'(halt), 64'd0);
        bp_write(1'b0, 1'b1, 2'd1, 16'h0003);
        hit1(1, 16'h0003);
        step();
        chk("bp_lowest_halt", 64'(halt), 64'd1);
        chk("bp_lowest_idx", 64'(halt_bp), 64'd0);

        // Full FIFO: 17 hits with no reads
        do_reset();
        for (int s = 1; s <= 17; s++) begin
            hit_valid = 4'b0001;
            hit_stmt  = 64'(s);
            step();
        end
        hit_valid = 4'b0;
        chk("full_cnt16", 64'(count), 64'd16);
        chk("full_no_ovf_yet", 64'(overflow), 64'd0);
        step();
        chk("full_cnt_after17", 64'(count), 64'd16);
        chk("full_ovf", 64'(overflow), 64'd1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("full_ovf_clr", 64'(overflow), 64'd0);
        hit1(0, 16'h0099);
        rd_ready = 1'b1;
        step();
        chk("full_pushpop_cnt", 64'(count), 64'd16);
        chk("full_pushpop_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 15; i++) begin
`ifdef STMT_TRACE_WRAP_EN
            exp_s[i] = 16'(i + 3);
`else
            exp_s[i] = 16'(i + 2);
`endif
        end
        exp_s[15] = 16'h0099;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_rd%0d", i), 64'(rd_data), 64'(ent(2'd0, exp_s[i])));
            step();
        end
        rd_ready = 1'b0;
        chk("full_drained_valid", 64'(rd_valid), 64'd0);
        chk("full_drained_cnt", 64'(count), 64'd0);

        // Asynchronous reset mid-operation
        do_reset();
        bp_write(1'b0, 1'b1, 2'd2, 16'h0009);
        hit_valid = 4'b1111; hit_stmt = 64'h0004_0009_0002_0001;
        step();
        hit_valid = 4'b0010; hit_stmt = 64'h0000_0000_0055_0000;
        step();
        hit_valid = 4'b0000;
        repeat (3) step();
        hit1(0, 16'h0005);
        step();
        chk("mid_pre_count", 64'(count), 64'd5);
        chk("mid_pre_halt", 64'(halt), 64'd1);
        chk("mid_pre_halt_bp", 64'(halt_bp), 64'd0);
        chk("mid_pre_ovf", 64'(overflow), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_halt", 64'(halt), 64'd0);
        chk("mid_rst_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        #1 rst_n = 1'b1;
        hit1(2, 16'h0009);
        step();
        chk("mid_post_halt", 64'(halt), 64'd0);
        chk("mid_post_count", 64'(count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
